// File: rtl/csi_hdr_ecc_check_pkg.sv
// ============================================================================
//  Module   : csi_ecc_pkg
//  Purpose  : Shared constants, status encoding and parity helper for the
//             CSI-2 packet-header ECC checker.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package csi_ecc_pkg;

  localparam int SYN_W  = 6;
  localparam int HDR_W  = 32;
  localparam int DATA_W = 24;

  // Column value of each data bit: the set of parity bits P5..P0 it feeds.
  // Listed from bit 23 down to bit 0.
  localparam logic [DATA_W-1:0][SYN_W-1:0] c_col_tbl = {
    6'h3B, 6'h37, 6'h2F, 6'h1F,
    6'h38, 6'h34, 6'h32, 6'h31, 6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23,
    6'h1C, 6'h1A, 6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07
  };

  // Per-channel check result; ECC_NONE marks a disabled channel.
  typedef enum logic [1:0] {
    ECC_NONE   = 2'd0,
    ECC_OK     = 2'd1,
    ECC_CORR   = 2'd2,
    ECC_UNCORR = 2'd3
  } ecc_status_t;

  // Six parity bits over the 24 header data bits.
  function automatic logic [SYN_W-1:0] ecc_parity(input logic [DATA_W-1:0] d);
    logic [SYN_W-1:0] p;
    p = '0;
    for (int j = 0; j < DATA_W; j++) begin
      if (d[j]) p = p ^ c_col_tbl[j];
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/csi_hdr_ecc_check_syndrome.sv
// ============================================================================
//  Module   : csi_ecc_syndrome
//  Purpose  : Combinational ECC logic for one header: syndrome generation on
//             the incoming header, and correction/classification of a
//             previously registered header and syndrome.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csi_ecc_syndrome
  import csi_ecc_pkg::*;
(
  input  logic [HDR_W-1:0] hdr,
  output logic [SYN_W-1:0] syn,
  input  logic [HDR_W-1:0] fix_hdr_in,
  input  logic [SYN_W-1:0] fix_syn,
  input  logic             fix_en,
  output logic [HDR_W-1:0] fix_hdr_out,
  output ecc_status_t      fix_status
);

  logic [DATA_W-1:0] w_flip;
  logic              w_hit;
  logic              w_ecc_bit_err;
  logic [DATA_W-1:0] w_fixed_data;
  logic [1:0]        w_unused_ecc_hi;

  // Received ECC[7:6] carry no information and are ignored.
  assign w_unused_ecc_hi = hdr[31:30];
  assign syn = hdr[29:24] ^ ecc_parity(hdr[23:0]);

  // Locate the data bit whose column matches the syndrome.
  always_comb begin
    w_flip = '0;
    w_hit  = 1'b0;
    for (int j = 0; j < DATA_W; j++) begin
      if (fix_syn == c_col_tbl[j]) begin
        w_flip[j] = 1'b1;
        w_hit     = 1'b1;
      end
    end
  end

  // A one-hot syndrome points at a flipped ECC bit; the data is intact.
  assign w_ecc_bit_err = $onehot(fix_syn);
  assign w_fixed_data  = fix_hdr_in[23:0] ^ w_flip;

  // Classify and build the outgoing header with a regenerated ECC byte.
  always_comb begin
    fix_hdr_out = fix_hdr_in;
    fix_status  = ECC_NONE;
    if (fix_en) begin
      if ((fix_syn == '0) || w_hit || w_ecc_bit_err) begin
        fix_hdr_out = {2'b00, ecc_parity(w_fixed_data), w_fixed_data};
        fix_status  = (fix_syn == '0) ? ECC_OK : ECC_CORR;
      end else begin
        fix_status  = ECC_UNCORR;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/csi_hdr_ecc_check.sv
// ============================================================================
//  Module   : csi_hdr_ecc_check
//  Purpose  : Two-stage pipelined MIPI CSI-2 packet-header ECC checker and
//             corrector for NUM_CH headers per beat, valid/ready handshake.
//             Build option HDR_ECC_ERR_CNT_EN adds saturating counters of
//             corrected and uncorrectable headers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csi_hdr_ecc_check
  import csi_ecc_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [HDR_W*NUM_CH-1:0] s_hdr,
  input  logic [NUM_CH-1:0]       s_chen,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [HDR_W*NUM_CH-1:0] m_hdr,
  output logic [NUM_CH-1:0]       m_ok,
  output logic [NUM_CH-1:0]       m_corr,
  output logic [NUM_CH-1:0]       m_uncorr,
  output logic [CNT_W-1:0]        cnt_corr,
  output logic [CNT_W-1:0]        cnt_uncorr,
  input  logic                    cnt_clr
);

  logic                    r_s1_valid;
  logic [HDR_W*NUM_CH-1:0] r_s1_hdr;
  logic [SYN_W*NUM_CH-1:0] r_s1_syn;
  logic [NUM_CH-1:0]       r_s1_en;

  logic                    r_m_valid;
  logic [HDR_W*NUM_CH-1:0] r_m_hdr;
  logic [NUM_CH-1:0]       r_m_ok;
  logic [NUM_CH-1:0]       r_m_corr;
  logic [NUM_CH-1:0]       r_m_uncorr;

  logic [SYN_W*NUM_CH-1:0] w_syn;
  logic [HDR_W*NUM_CH-1:0] w_fix_hdr;
  ecc_status_t             w_status [NUM_CH];
  logic [NUM_CH-1:0]       w_ok;
  logic [NUM_CH-1:0]       w_corr;
  logic [NUM_CH-1:0]       w_uncorr;
  logic                    w_s2_load;

  // Output stage takes a new beat when empty or drained this cycle; stage 1
  // then follows whenever it is empty or moves into the output stage.
  assign w_s2_load = !r_m_valid || m_ready;
  assign s_ready   = !r_s1_valid || w_s2_load;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      csi_ecc_syndrome u_syn (
        .hdr         (s_hdr[HDR_W*c +: HDR_W]),
        .syn         (w_syn[SYN_W*c +: SYN_W]),
        .fix_hdr_in  (r_s1_hdr[HDR_W*c +: HDR_W]),
        .fix_syn     (r_s1_syn[SYN_W*c +: SYN_W]),
        .fix_en      (r_s1_en[c]),
        .fix_hdr_out (w_fix_hdr[HDR_W*c +: HDR_W]),
        .fix_status  (w_status[c])
      );
      assign w_ok[c]     = (w_status[c] == ECC_OK);
      assign w_corr[c]   = (w_status[c] == ECC_CORR);
      assign w_uncorr[c] = (w_status[c] == ECC_UNCORR);
    end
  endgenerate

  // Stage 1: capture accepted header, enables and syndrome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_hdr   <= '0;
      r_s1_syn   <= '0;
      r_s1_en    <= '0;
    end else if (s_ready) begin
      r_s1_valid <= s_valid;
      if (s_valid) begin
        r_s1_hdr <= s_hdr;
        r_s1_syn <= w_syn;
        r_s1_en  <= s_chen;
      end
    end
  end

  // Stage 2: register corrected headers and status; held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid  <= 1'b0;
      r_m_hdr    <= '0;
      r_m_ok     <= '0;
      r_m_corr   <= '0;
      r_m_uncorr <= '0;
    end else if (w_s2_load) begin
      r_m_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_m_hdr    <= w_fix_hdr;
        r_m_ok     <= w_ok;
        r_m_corr   <= w_corr;
        r_m_uncorr <= w_uncorr;
      end
    end
  end

  assign m_valid  = r_m_valid;
  assign m_hdr    = r_m_hdr;
  assign m_ok     = r_m_ok;
  assign m_corr   = r_m_corr;
  assign m_uncorr = r_m_uncorr;

`ifdef HDR_ECC_ERR_CNT_EN
  // Four spare bits hold the sum of up to 8 increments before saturation.
  localparam int SUM_W = CNT_W + 4;
  localparam logic [SUM_W-1:0] c_cnt_max = {4'b0000, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] r_cnt_corr;
  logic [CNT_W-1:0] r_cnt_uncorr;
  logic [SUM_W-1:0] w_sum_corr;
  logic [SUM_W-1:0] w_sum_uncorr;
  logic             w_out_fire;

  assign w_out_fire = r_m_valid && m_ready;

  // Add this beat's flag population to each counter, clamped at all-ones.
  always_comb begin
    w_sum_corr   = {4'b0000, r_cnt_corr};
    w_sum_uncorr = {4'b0000, r_cnt_uncorr};
    for (int c = 0; c < NUM_CH; c++) begin
      w_sum_corr   = w_sum_corr   + SUM_W'(r_m_corr[c]);
      w_sum_uncorr = w_sum_uncorr + SUM_W'(r_m_uncorr[c]);
    end
    if (w_sum_corr > c_cnt_max)   w_sum_corr   = c_cnt_max;
    if (w_sum_uncorr > c_cnt_max) w_sum_uncorr = c_cnt_max;
  end

  // Counters update on output handshake; clear wins over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_corr   <= '0;
      r_cnt_uncorr <= '0;
    end else if (cnt_clr) begin
      r_cnt_corr   <= '0;
      r_cnt_uncorr <= '0;
    end else if (w_out_fire) begin
      r_cnt_corr   <= w_sum_corr[CNT_W-1:0];
      r_cnt_uncorr <= w_sum_uncorr[CNT_W-1:0];
    end
  end

  assign cnt_corr   = r_cnt_corr;
  assign cnt_uncorr = r_cnt_uncorr;
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = cnt_clr;
  assign cnt_corr         = '0;
  assign cnt_uncorr       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_csi_hdr_ecc_check.sv
// ============================================================================
//  Module   : tb_csi_hdr_ecc_check
//  Purpose  : Self-checking bench for csi_hdr_ecc_check (NUM_CH=4, CNT_W=4).
//             Expected beats come from a search-based decoder model; counter
//             expectations follow HDR_ECC_ERR_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csi_hdr_ecc_check;

  localparam int N       = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef HDR_ECC_ERR_CNT_EN
  localparam int CNT_ON  = 1;
`else
  localparam int CNT_ON  = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [32*N-1:0] s_hdr = '0;
  logic [N-1:0]    s_chen = '0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [32*N-1:0] m_hdr;
  logic [N-1:0]    m_ok;
  logic [N-1:0]    m_corr;
  logic [N-1:0]    m_uncorr;
  logic [CW-1:0]   cnt_corr;
  logic [CW-1:0]   cnt_uncorr;
  logic            cnt_clr = 1'b0;

  always #5 clk = ~clk;

  csi_hdr_ecc_check #(.NUM_CH(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_hdr      (s_hdr),
    .s_chen     (s_chen),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_hdr      (m_hdr),
    .m_ok       (m_ok),
    .m_corr     (m_corr),
    .m_uncorr   (m_uncorr),
    .cnt_corr   (cnt_corr),
    .cnt_uncorr (cnt_uncorr),
    .cnt_clr    (cnt_clr)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [32*N-1:0] hdr;
    logic [N-1:0]    ok;
    logic [N-1:0]    corr;
    logic [N-1:0]    uncorr;
  } beat_t;

  beat_t q[$];
  int    mdl_corr = 0;
  int    mdl_uncorr = 0;
  logic  last_in_fire = 1'b0;

  logic [5:0] col [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                           6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                           6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Parity bit k = XOR of every data bit whose column includes k.
  function automatic logic [5:0] ref_ecc(input logic [23:0] d);
    logic [5:0] p;
    for (int k = 0; k < 6; k++) begin
      p[k] = 1'b0;
      for (int j = 0; j < 24; j++) if (col[j][k]) p[k] = p[k] ^ d[j];
    end
    return p;
  endfunction

  // Decode by search: valid codeword, else try every single-bit flip.
  function automatic void ref_hdr(input logic [31:0] h, input logic en,
                                  output logic [31:0] o, output logic ok,
                                  output logic corr, output logic uncorr);
    logic [29:0] t;
    o = h; ok = 1'b0; corr = 1'b0; uncorr = 1'b0;
    if (!en) return;
    if (ref_ecc(h[23:0]) == h[29:24]) begin
      ok = 1'b1; o = {2'b00, h[29:0]};
      return;
    end
    for (int b = 0; b < 30; b++) begin
      t = h[29:0];
      t[b] = ~t[b];
      if (ref_ecc(t[23:0]) == t[29:24]) begin
        corr = 1'b1; o = {2'b00, t};
        return;
      end
    end
    uncorr = 1'b1;
  endfunction

  function automatic beat_t ref_beat(input logic [32*N-1:0] hv, input logic [N-1:0] en);
    beat_t r;
    logic [31:0] o;
    logic a, b, c2;
    for (int c = 0; c < N; c++) begin
      ref_hdr(hv[32*c +: 32], en[c], o, a, b, c2);
      r.hdr[32*c +: 32] = o;
      r.ok[c] = a; r.corr[c] = b; r.uncorr[c] = c2;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_hdr();
    logic [23:0] d;
    logic [31:0] h;
    int nflip;
    d = 24'($urandom);
    h = {2'($urandom), ref_ecc(d), d};
    nflip = $urandom_range(0, 2);
    for (int i = 0; i < nflip; i++) h[$urandom_range(0, 31)] ^= 1'b1;
    return h;
  endfunction

  // One clock: check outputs and counters at negedge, update the model,
  // then return 1 time unit after the rising edge.
  task automatic tick();
    logic in_fire, out_fire;
    beat_t e;
    @(negedge clk);
    in_fire  = s_valid & s_ready;
    out_fire = m_valid & m_ready;
    chk("cnt_corr", 32'(cnt_corr), 32'(mdl_corr));
    chk("cnt_uncorr", 32'(cnt_uncorr), 32'(mdl_uncorr));
    if (m_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'(m_valid), 32'd0);
      end else begin
        e = q[0];
        for (int c = 0; c < N; c++) begin
          chk("out_hdr", m_hdr[32*c +: 32], e.hdr[32*c +: 32]);
          chk("out_flags", {29'd0, m_ok[c], m_corr[c], m_uncorr[c]},
              {29'd0, e.ok[c], e.corr[c], e.uncorr[c]});
        end
        if (out_fire) begin
          void'(q.pop_front());
          if (CNT_ON == 1 && !cnt_clr) begin
            mdl_corr   = mdl_corr + $countones(e.corr);
            mdl_uncorr = mdl_uncorr + $countones(e.uncorr);
            if (mdl_corr > CNT_MAX)   mdl_corr = CNT_MAX;
            if (mdl_uncorr > CNT_MAX) mdl_uncorr = CNT_MAX;
          end
        end
      end
    end
    if (cnt_clr) begin
      mdl_corr = 0;
      mdl_uncorr = 0;
    end
    if (in_fire) q.push_back(ref_beat(s_hdr, s_chen));
    last_in_fire = in_fire;
    @(posedge clk);
    #1;
  endtask

  // Single beat on channel 0, checked against fixed values and latency.
  task automatic directed(input string tag, input logic [31:0] h, input logic [N-1:0] en,
                          input logic [31:0] exp_h, input logic [2:0] exp_f);
    s_hdr = {rand_hdr(), rand_hdr(), rand_hdr(), h};
    s_chen = en;
    s_valid = 1'b1;
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(m_valid), 32'd0);
    tick();
    chk({tag, "_lat2"}, 32'(m_valid), 32'd1);
    chk({tag, "_hdr"}, m_hdr[31:0], exp_h);
    chk({tag, "_flags"}, {29'd0, m_ok[0], m_corr[0], m_uncorr[0]}, {29'd0, exp_f});
    tick();
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    for (int c = 0; c < N; c++) chk("rst_m_hdr", m_hdr[32*c +: 32], 32'd0);
    chk("rst_flags", {20'd0, m_ok, m_corr, m_uncorr}, 32'd0);
    chk("rst_cnt", {24'd0, cnt_corr, cnt_uncorr}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd1);

    // Directed patterns on channel 0 (flags order ok,corr,uncorr)
    directed("clean0", 32'h00000000, 4'b0001, 32'h00000000, 3'b100);
    directed("cleanF", 32'h3CFFFFFF, 4'b0001, 32'h3CFFFFFF, 3'b100);
    directed("dataerr", 32'h00100000, 4'b0001, 32'h00000000, 3'b010);
    chk("cnt_corr_1", 32'(cnt_corr), 32'(CNT_ON));
    directed("eccerr", 32'h08000000, 4'b0001, 32'h00000000, 3'b010);
    directed("double", 32'h00000003, 4'b0001, 32'h00000003, 3'b001);
    chk("cnt_uncorr_1", 32'(cnt_uncorr), 32'(CNT_ON));
    chk("cnt_corr_2", 32'(cnt_corr), 32'(2 * CNT_ON));
    directed("ecc_hi", 32'hC0000000, 4'b0001, 32'h00000000, 3'b100);
    directed("disabled", 32'h00000003, 4'b0000, 32'h00000003, 3'b000);

    // Random traffic with 50% backpressure on all channels
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!s_valid || last_in_fire) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_hdr = {rand_hdr(), rand_hdr(), rand_hdr(), rand_hdr()};
        s_chen = 4'($urandom);
      end
      m_ready = 1'($urandom);
      tick();
    end
    drain();

    // Saturation: 20 corrected beats into a 4-bit counter
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    s_chen = 4'b0001;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_hdr = {rand_hdr(), rand_hdr(), rand_hdr(), 32'h00100000};
      s_valid = 1'b1;
      tick();
    end
    drain();
    chk("sat_corr", 32'(cnt_corr), 32'(CNT_ON * CNT_MAX));

    // Clear coinciding with an increment
    s_hdr = {rand_hdr(), rand_hdr(), rand_hdr(), 32'h00100000};
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    chk("clr_pre_valid", 32'(m_valid), 32'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_priority", 32'(cnt_corr), 32'd0);

    // Reset with two beats in flight
    m_ready = 1'b0;
    s_hdr = {rand_hdr(), rand_hdr(), rand_hdr(), 32'h00000003};
    s_valid = 1'b1;
    tick();
    tick();
    s_valid = 1'b0;
    chk("inflight_valid", 32'(m_valid), 32'd1);
    chk("inflight_stall", 32'(s_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(m_valid), 32'd0);
    q.delete();
    mdl_corr = 0;
    mdl_uncorr = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("postrst_valid", 32'(m_valid), 32'd0);
    end
    directed("postrst", 32'h00100000, 4'b0001, 32'h00000000, 3'b010);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
